// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle unsigned/signed magnitude comparator. Scans DIGIT bits per cycle, MSB chunk first.
// Define SEQ_COMPARATOR_EARLY_EXIT_EN to finish on the first differing chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_signed;
  logic [IDXW-1:0]   r_idx;
  logic              r_decided;
  logic              r_dec_gt;
  logic              r_dec_lt;
  logic              r_out_valid;
  logic              r_eq;
  logic              r_gt;
  logic              r_lt;

  logic [DIGIT-1:0]  w_chunk_a;
  logic [DIGIT-1:0]  w_chunk_b;
  logic [DIGIT-1:0]  w_flip;
  logic              w_differ;
  logic              w_gt_next;
  logic              w_lt_next;
  logic              w_finish;

  // Signed compare: flipping the sign bit of the top chunk maps two's complement onto unsigned order.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_flip    = DIGIT'(r_signed && (r_idx == LAST_IDX)) << (DIGIT - 1);
    w_chunk_a = r_a[int'(r_idx)*DIGIT +: DIGIT] ^ w_flip;
    w_chunk_b = r_b[int'(r_idx)*DIGIT +: DIGIT] ^ w_flip;
    w_differ  = (w_chunk_a != w_chunk_b);
    w_gt_next = r_dec_gt;
    w_lt_next = r_dec_lt;
    if (!r_decided && w_differ) begin
      w_gt_next = (w_chunk_a > w_chunk_b);
      w_lt_next = (w_chunk_a < w_chunk_b);
    end
  end

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
  assign w_finish = (r_idx == '0) || (!r_decided && w_differ);
`else
  assign w_finish = (r_idx == '0);
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign eq        = r_eq;
  assign gt        = r_gt;
  assign lt        = r_lt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_decided   <= 1'b0;
      r_dec_gt    <= 1'b0;
      r_dec_lt    <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state   <= SCAN;
            r_idx     <= LAST_IDX;
            r_decided <= 1'b0;
            r_dec_gt  <= 1'b0;
            r_dec_lt  <= 1'b0;
          end
        end
        SCAN: begin
          r_idx    <= r_idx - 1'b1;
          r_dec_gt <= w_gt_next;
          r_dec_lt <= w_lt_next;
          if (w_differ) r_decided <= 1'b1;
          if (w_finish) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_gt        <= w_gt_next;
            r_lt        <= w_lt_next;
            r_eq        <= ~w_gt_next & ~w_lt_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: operand registers carry no reset; they are only read after a capture in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid && !rst) begin
      r_a      <= a;
      r_b      <= b;
      r_signed <= signed_mode;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4), latency aware of SEQ_COMPARATOR_EARLY_EXIT_EN.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic        eq;
  logic        gt;
  logic        lt;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;
  localparam logic [2:0] R_NONE = 3'b000;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int early_lat);
    return EARLY ? early_lat : 5;
  endfunction

  // Accept operands (ends cycle 0), then run to out_valid, returning the cycle it rose in.
  task automatic start(input logic [15:0] va, input logic [15:0] vb, input logic sm, output int cyc);
    a = va; b = vb; signed_mode = sm; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] va, input logic [15:0] vb,
                     input logic sm, input logic [2:0] exp_res, input int exp_lat);
    int cyc;
    out_ready = 1'b1;
    start(va, vb, sm, cyc);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, {eq, gt, lt}, exp_res);
    check({tag, " busy"}, in_ready, 1'b0);
    step();
    check({tag, " idle"}, {in_ready, out_valid, eq, gt, lt}, 5'b10000);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("reset state", {in_ready, out_valid, eq, gt, lt}, 5'b10000);
    rst = 1'b0;

    run("t1 eq",          16'h1234, 16'h1234, 1'b0, R_EQ, 5);
    run("t2 unsigned",    16'h8000, 16'h0001, 1'b0, R_GT, lat(2));
    run("t2 signed",      16'h8000, 16'h0001, 1'b1, R_LT, lat(2));
    run("t3 -1>-2",       16'hFFFF, 16'hFFFE, 1'b1, R_GT, 5);
    run("t3 0>-1",        16'h0000, 16'hFFFF, 1'b1, R_GT, lat(2));
    run("t3 7fff<8000",   16'h7FFF, 16'h8000, 1'b0, R_LT, lat(2));
    run("t4 early gt",    16'hA000, 16'h5000, 1'b0, R_GT, lat(2));
    run("t4 late lt",     16'h0001, 16'h0002, 1'b0, R_LT, 5);

    // Back-pressure: result must hold through cycles 5..8.
    out_ready = 1'b0;
    start(16'h1234, 16'h1234, 1'b0, cyc);
    check("t5 latency", cyc, 5);
    for (int c = 5; c <= 7; c++) begin
      check($sformatf("t5 hold c%0d", c), {in_ready, out_valid, eq, gt, lt}, 5'b01100);
      step();
    end
    out_ready = 1'b1;
    check("t5 hold c8", {in_ready, out_valid, eq, gt, lt}, 5'b01100);
    step();
    check("t5 release c9", {in_ready, out_valid, eq, gt, lt}, 5'b10000);

    // Reset in cycle 2 aborts the compare and ignores the concurrent in_valid.
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("t6 after reset", {in_ready, out_valid, eq, gt, lt}, 5'b10000);
    for (int i = 0; i < 5; i++) step();
    check("t6 no accept", {in_ready, out_valid, eq, gt, lt}, 5'b10000);
    run("t6 fresh lt", 16'h0010, 16'h0020, 1'b0, R_LT, lat(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
